// File: rtl/prio_pkg.sv
// Shared types and limits for the registered priority encoder.
package prio_pkg;

  localparam int MAX_N = 64;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/prio_pick.sv
// Combinational wrap-around highest-first search: checks start, start-1, ...
// modulo N and reports the first set bit of cand.
module prio_pick
  import prio_pkg::*;
#(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     cand,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int               p;
  logic [IDX_W-1:0] pos;

  always_comb begin
    idx = '0;
    any = 1'b0;
    p   = 0;
    pos = '0;
    for (int i = 0; i < N; i++) begin
      p = int'(start) - i;
      if (p < 0) p = p + N;
      pos = IDX_W'(p);
      if (!any && cand[pos]) begin
        any = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/prio_encoder_seq.sv
// Registered N-input priority encoder with sticky requests and a valid/ready
// index output. Define PRIO_RR_EN for round-robin instead of fixed priority.
module prio_encoder_seq
  import prio_pkg::*;
#(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     pending
);

  if (N < 2 || N > MAX_N) begin : g_bad_n
    $error("prio_encoder_seq: N out of range");
  end

  // Handshake: out_idx is offered while out_valid is high and is transferred
  // on any rising edge where out_valid && out_ready; out_idx/out_valid never
  // change without that transfer, except on reset.
  state_t           state;
  logic             accept;
  logic [N-1:0]     clr_mask;
  logic [N-1:0]     cand;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] win;
  logic             any;

  assign accept   = out_valid && out_ready;
  assign clr_mask = accept ? (N'(1) << out_idx) : '0;
  // A request arriving on the accept cycle of the same index keeps it pending.
  assign cand     = (pending & ~clr_mask) | req;

`ifdef PRIO_RR_EN
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] base;

  // On an accept the winner for the same edge already searches after the
  // index being accepted, so back-to-back grants rotate without a bubble.
  assign base  = accept ? out_idx : rr_ptr;
  assign start = (base == '0) ? IDX_W'(N - 1) : base - IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= out_idx;
    end
  end
`else
  assign start = IDX_W'(N - 1);
`endif

  prio_pick #(.N(N)) u_pick (
    .cand  (cand),
    .start (start),
    .idx   (win),
    .any   (any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
      pending   <= '0;
    end else begin
      pending <= cand;
      case (state)
        IDLE: begin
          if (en && any) begin
            out_idx   <= win;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (accept) begin
            if (en && any) begin
              out_idx <= win;
            end else begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prio_encoder_seq.sv
// Bench for prio_encoder_seq: directed scenarios plus random traffic checked
// against a behavioural model through an expected-grant queue.
module tb_prio_encoder_seq;

  localparam int N     = 8;
  localparam int IDX_W = $clog2(N);

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [N-1:0]     req;
  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     pending;

  int total = 0;
  int bad   = 0;

  logic [IDX_W-1:0] exp_q[$];

  // Reference model state
  logic [N-1:0]     m_pend  = '0;
  logic             m_valid = 1'b0;
  logic [IDX_W-1:0] m_cur   = '0;
  int               m_ptr   = 0;

  prio_encoder_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Priority order: ptr-1, ptr-2, ... modulo N, ptr itself last.
  function automatic int ref_pick(input logic [N-1:0] p, input int ptr);
    for (int i = 1; i <= N; i++) begin
      int k;
      k = ((ptr - i) % N + N) % N;
      if (p[k]) return k;
    end
    return -1;
  endfunction

  // ---------------- reference model ----------------
  always @(posedge clk) begin
    logic [N-1:0] nxt;
    logic         acc;
    if (rst) begin
      m_pend  = '0;
      m_valid = 1'b0;
      m_ptr   = 0;
      exp_q.delete();
    end else begin
      acc = m_valid && out_ready;
      nxt = m_pend;
      if (acc) begin
        nxt[m_cur] = 1'b0;
`ifdef PRIO_RR_EN
        m_ptr = int'(m_cur);
`endif
      end
      nxt = nxt | req;
      if (!m_valid || acc) begin
        if (en && nxt != '0) begin
          m_cur   = IDX_W'(ref_pick(nxt, m_ptr));
          m_valid = 1'b1;
          exp_q.push_back(m_cur);
        end else begin
          m_valid = 1'b0;
        end
      end
      m_pend = nxt;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    check("mon_valid", 64'(out_valid), 64'(m_valid));
    check("mon_pending", 64'(pending), 64'(m_pend));
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon_idx: got %0d with no expected grant queued at %0t", out_idx, $time);
      end else begin
        check("mon_idx", 64'(out_idx), 64'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (!out_valid) break;
    end
    check("drain_idle", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [IDX_W-1:0] seq_exp [6];
  int               got;

  initial begin
`ifdef PRIO_RR_EN
    seq_exp = '{3'd7, 3'd3, 3'd0, 3'd7, 3'd3, 3'd0};
`else
    seq_exp = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
`endif
    rst       = 1'b1;
    en        = 1'b1;
    req       = 8'hFF;
    out_ready = 1'b0;

    // Reset drops requests present during reset
    repeat (2) tick();
    rst = 1'b0;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_idx", 64'(out_idx), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    tick();
    check("first_valid", 64'(out_valid), 64'd1);
    check("first_idx", 64'(out_idx), 64'd7);
    req = '0;
    drain();

    // Fixed priority with a stall
    req = 8'b0010_0100;
    tick();
    req = '0;
    check("stall_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check("stall_idx", 64'(out_idx), 64'd5);
      tick();
    end
    check("stall_idx_end", 64'(out_idx), 64'd5);
    out_ready = 1'b1;
    tick();
    check("b2b_valid", 64'(out_valid), 64'd1);
    check("b2b_idx", 64'(out_idx), 64'd2);
    tick();
    check("after_b2b_valid", 64'(out_valid), 64'd0);
    check("after_b2b_pending", 64'(pending), 64'd0);
    out_ready = 1'b0;

    // Same-cycle re-request keeps the bit pending
    req = 8'h08;
    tick();
    req = '0;
    check("rereq_idx", 64'(out_idx), 64'd3);
    out_ready = 1'b1;
    req = 8'h08;
    tick();
    req = '0;
    check("rereq_pending", 64'(pending), 64'h08);
    check("rereq_valid", 64'(out_valid), 64'd1);
    check("rereq_idx2", 64'(out_idx), 64'd3);
    tick();
    check("rereq_done_valid", 64'(out_valid), 64'd0);
    check("rereq_done_pending", 64'(pending), 64'd0);
    out_ready = 1'b0;

    // Enable gating captures but does not grant
    do_reset();
    en  = 1'b0;
    req = 8'h81;
    tick();
    req = '0;
    check("en_valid", 64'(out_valid), 64'd0);
    check("en_pending", 64'(pending), 64'h81);
    tick();
    check("en_valid2", 64'(out_valid), 64'd0);
    en = 1'b1;
    tick();
    check("en_grant_valid", 64'(out_valid), 64'd1);
    check("en_grant_idx", 64'(out_idx), 64'd7);
    drain();

    // Held requests: rotation (round-robin) or repeated top index (fixed)
    do_reset();
    req       = 8'h89;
    out_ready = 1'b1;
    got       = 0;
    for (int c = 0; c < 30 && got < 6; c++) begin
      tick();
      if (out_valid) begin
        check("held_seq", 64'(out_idx), 64'(seq_exp[got]));
        got++;
      end
    end
    check("held_count", 64'(got), 64'd6);
    req = '0;
    drain();

    // Reset in the middle of a held grant
    do_reset();
    req = 8'h41;
    tick();
    req = '0;
    check("midrst_pre_idx", 64'(out_idx), 64'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_idx", 64'(out_idx), 64'd0);
    check("midrst_pending", 64'(pending), 64'd0);
    tick();
    check("midrst_stay_idle", 64'(out_valid), 64'd0);

    // Random traffic, checked by the monitor against the model
    for (int c = 0; c < 2000; c++) begin
      req       = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      en        = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    req = '0;
    en  = 1'b1;
    drain();

    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
